// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ stage controller.
//   - icode constants for the instruction classes the sequencer cares about
//   - processor status codes driven on stat
//   - sequencer state enumeration
//   - helper that classifies icodes needing a data-memory access
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPDATE  = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
           (ic == IRET)    || (ic == IPUSHQ)  || (ic == IPOPQ);
  endfunction

endpackage

// File: rtl/y86_cc_reg.sv
// Architectural condition-code register (ZF/SF/OF).
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   we             load strobe
//   cc_in[2:0]     {zf, sf, of} to load
//   cc_out[2:0]    registered {zf, sf, of}; resets to ZF=1, SF=0, OF=0
module y86_cc_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [2:0] cc_in,
  output logic [2:0] cc_out
);

  logic [2:0] cc_q, cc_d;

  always_comb begin
    cc_d = cc_q;
    if (we) cc_d = cc_in;
  end

  always_ff @(posedge clk) begin
    if (reset) cc_q <= 3'b100;
    else       cc_q <= cc_d;
  end

  assign cc_out = cc_q;

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: one stage per cycle,
// data-memory wait with timeout, condition-code ownership and status tracking.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      level request to run from IDLE / continue after PCUPDATE
//   icode, instr_valid,
//   imem_error                 fetch-stage results
//   mem_ready, dmem_error      data-memory handshake
//   alu_zf, alu_sf, alu_of     execute-stage flags
//   *_en                       one-hot stage enables (Moore)
//   cc_we                      condition-code write strobe
//   ZF, SF, OF                 registered condition codes
//   stat, halted, instr_count  status, stopped flag, retired-instruction count
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | fetch enabled; classify halt / illegal / fetch fault
// DECODE    | decode enabled
// EXECUTE   | execute enabled; OPq loads condition codes
// MEMORY    | memory enabled; memory-class icodes wait for mem_ready
// WRITEBACK | writeback enabled
// PCUPDATE  | PC update enabled; instruction retires
// HALT      | stopped until reset
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ready,
  input  logic             dmem_error,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic             cc_we,
  output logic             ZF,
  output logic             SF,
  output logic             OF,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [7:0]       TMO_LIM = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stat_q  <= SAOK;
      tmo_q   <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          stat_d  = SADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = SINS;
          state_d = S_HALT;
        end else if (icode == IHALT) begin
          stat_d  = SHLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        tmo_d   = 8'd0;
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        if (!is_mem_icode(icode)) begin
          state_d = S_WRITEBACK;
        end else if (mem_ready) begin
          if (dmem_error) begin
            stat_d  = SADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else begin
          // The waiting cycle that brings the count to the limit gives up.
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TMO_LIM) begin
            stat_d  = SADR;
            state_d = S_HALT;
          end
        end
      end
      S_WRITEBACK: state_d = S_PCUPDATE;
      S_PCUPDATE: begin
        cnt_d   = cnt_q + CNT_ONE;
        state_d = start ? S_FETCH : S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_en     = (state_q == S_FETCH);
    decode_en    = (state_q == S_DECODE);
    execute_en   = (state_q == S_EXECUTE);
    memory_en    = (state_q == S_MEMORY);
    writeback_en = (state_q == S_WRITEBACK);
    pc_en        = (state_q == S_PCUPDATE);
    halted       = (state_q == S_HALT);
    cc_we        = (state_q == S_EXECUTE) && (icode == IOPQ);
  end

  y86_cc_reg u_cc (
    .clk    (clk),
    .reset  (reset),
    .we     (cc_we),
    .cc_in  ({alu_zf, alu_sf, alu_of}),
    .cc_out (cc_q)
  );

  assign ZF          = cc_q[2];
  assign SF          = cc_q[1];
  assign OF          = cc_q[0];
  assign stat        = stat_q;
  assign instr_count = cnt_q;

endmodule
